// File: rtl/vx_credit_return.sv
// rtl/vx_credit_return.sv - receiver-side batched credit return generator
//
// Collects buffer slots freed by the local consumer and hands them back to
// the sender in batched credit packets. A partial batch is bounded in latency
// by a timeout and by an explicit flush. The accumulator counts every credit
// not yet accepted by the sender, including the packet currently on the port.

module vx_credit_return #(
    parameter int SIZE    = 16,
    parameter int FREEW   = 2,
    parameter int BATCH   = 4,
    parameter int TIMEOUT = 8,
    parameter int CREDITW = $clog2(SIZE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FREEW-1:0]   free_cnt,
    input  logic               flush,
    output logic               crd_valid,
    output logic [CREDITW-1:0] crd_count,
    input  logic               crd_ready,
    output logic [CREDITW-1:0] pending,
    output logic               idle
);

    // The timer only needs to reach TIMEOUT-1; keep at least one bit so the
    // TIMEOUT=0 build still has a legal (unused) register.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Thresholds pre-sized to the accumulator arithmetic width.
    localparam logic [CREDITW:0] SIZE_N     = (CREDITW + 1)'(SIZE);
    localparam logic [CREDITW:0] BATCH_N    = (CREDITW + 1)'(BATCH);
    localparam logic [TW-1:0]    TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam bit               TIMER_ON   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t             state;
    logic [CREDITW-1:0] acc;
    logic [TW-1:0]      timer;

    logic               fire;
    logic [CREDITW:0]   acc_n;
    logic               acc_zero;
    logic               reach_batch;
    logic               timed_out;

    // The accumulator register doubles as the pending-credit output.
    assign pending = acc;

    // Next accumulator: freed slots come in, an accepted packet goes out, both
    // in the same cycle if they coincide, so no credit is ever dropped.
    always_comb begin
        fire        = crd_valid & crd_ready;
        acc_n       = (CREDITW + 1)'(acc) + (CREDITW + 1)'(free_cnt)
                    - (fire ? (CREDITW + 1)'(crd_count) : '0);
        acc_zero    = (acc_n == '0);
        reach_batch = (acc_n >= BATCH_N);
        timed_out   = TIMER_ON && (timer == TIMER_LAST);
    end

    // Return FSM with registered packet, idle and accumulator state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            timer     <= '0;
            crd_valid <= 1'b0;
            crd_count <= '0;
            idle      <= 1'b1;
        end else begin
            acc <= acc_n[CREDITW-1:0];
            case (state)
                ST_IDLE: begin
                    if (acc_zero) begin
                        state <= ST_IDLE;
                        idle  <= 1'b1;
                    end else if (flush || reach_batch) begin
                        state     <= ST_SEND;
                        crd_valid <= 1'b1;
                        crd_count <= acc_n[CREDITW-1:0];
                        idle      <= 1'b0;
                    end else begin
                        state <= ST_ACCUM;
                        timer <= '0;
                        idle  <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (flush || reach_batch || timed_out) begin
                        state     <= ST_SEND;
                        crd_valid <= 1'b1;
                        crd_count <= acc_n[CREDITW-1:0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SEND: begin
                    // The packet is frozen until the sender takes it; new
                    // frees only grow the accumulator meanwhile.
                    if (fire) begin
                        if (acc_zero) begin
                            state     <= ST_IDLE;
                            crd_valid <= 1'b0;
                            crd_count <= '0;
                            idle      <= 1'b1;
                        end else if (reach_batch || flush) begin
                            state     <= ST_SEND;
                            crd_valid <= 1'b1;
                            crd_count <= acc_n[CREDITW-1:0];
                        end else begin
                            state     <= ST_ACCUM;
                            timer     <= '0;
                            crd_valid <= 1'b0;
                            crd_count <= '0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    crd_valid <= 1'b0;
                    crd_count <= '0;
                    idle      <= 1'b1;
                end
            endcase
        end
    end

    // More credits than the buffer holds means the consumer freed slots the
    // sender never filled.
    a_acc_bound: assert property (@(posedge clk) disable iff (reset) acc_n <= SIZE_N);

endmodule

// File: tb/tb_vx_credit_return.sv
// tb/tb_vx_credit_return.sv - directed self-checking bench for vx_credit_return

module tb_vx_credit_return;

    localparam int SIZE    = 16;
    localparam int FREEW   = 2;
    localparam int BATCH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CREDITW = $clog2(SIZE + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic [FREEW-1:0]   free_cnt;
    logic               flush;
    logic               crd_valid;
    logic [CREDITW-1:0] crd_count;
    logic               crd_ready;
    logic [CREDITW-1:0] pending;
    logic               idle;

    logic [FREEW-1:0]   nt_free_cnt;
    logic               nt_valid;
    logic [CREDITW-1:0] nt_count;
    logic [CREDITW-1:0] nt_pending;
    logic               nt_idle;
    logic               nt_seen = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vx_credit_return #(
        .SIZE(SIZE), .FREEW(FREEW), .BATCH(BATCH), .TIMEOUT(TIMEOUT), .CREDITW(CREDITW)
    ) u_dut (
        .clk(clk), .reset(reset), .free_cnt(free_cnt), .flush(flush),
        .crd_valid(crd_valid), .crd_count(crd_count), .crd_ready(crd_ready),
        .pending(pending), .idle(idle)
    );

    vx_credit_return #(
        .SIZE(SIZE), .FREEW(FREEW), .BATCH(BATCH), .TIMEOUT(0), .CREDITW(CREDITW)
    ) u_dut_nt (
        .clk(clk), .reset(reset), .free_cnt(nt_free_cnt), .flush(1'b0),
        .crd_valid(nt_valid), .crd_count(nt_count), .crd_ready(1'b1),
        .pending(nt_pending), .idle(nt_idle)
    );

    // Sticky record of any packet from the no-timeout instance.
    always @(negedge clk) begin
        if (nt_valid) nt_seen = 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int v, input int c, input int p, input int i);
        check({tag, ".valid"}, int'(crd_valid), v);
        check({tag, ".count"}, int'(crd_count), c);
        check({tag, ".pending"}, int'(pending), p);
        check({tag, ".idle"}, int'(idle), i);
    endtask

    initial begin
        reset       = 1'b1;
        free_cnt    = '0;
        flush       = 1'b0;
        crd_ready   = 1'b0;
        nt_free_cnt = '0;
        tick();
        tick();
        check_out("reset", 0, 0, 0, 1);
        reset = 1'b0;

        // 1: four single frees reach the batch threshold
        crd_ready = 1'b1;
        free_cnt  = 2'd1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_out($sformatf("batch.acc%0d", k), 0, 0, k, 0);
        end
        tick();
        check_out("batch.send", 1, 4, 4, 0);
        free_cnt = 2'd0;
        tick();
        check_out("batch.done", 0, 0, 0, 1);

        // 2: lone partial free waits out the timeout
        free_cnt    = 2'd1;
        nt_free_cnt = 2'd1;
        tick();
        free_cnt    = 2'd0;
        nt_free_cnt = 2'd0;
        check_out("tmo.accum", 0, 0, 1, 0);
        for (int k = 0; k < 7; k++) tick();
        check_out("tmo.edge", 0, 0, 1, 0);
        tick();
        check_out("tmo.send", 1, 1, 1, 0);
        tick();
        check_out("tmo.done", 0, 0, 0, 1);
        for (int k = 0; k < 12; k++) tick();
        check("nt.never_sent", int'(nt_seen), 0);
        check("nt.pending", int'(nt_pending), 1);
        check("nt.idle", int'(nt_idle), 0);

        // 3: backpressure holds the packet while credits keep arriving
        crd_ready = 1'b0;
        free_cnt  = 2'd1;
        for (int k = 0; k < 4; k++) tick();
        check_out("bp.send", 1, 4, 4, 0);
        free_cnt = 2'd2;
        tick();
        check_out("bp.hold1", 1, 4, 6, 0);
        tick();
        check_out("bp.hold2", 1, 4, 8, 0);
        tick();
        check_out("bp.hold3", 1, 4, 10, 0);
        free_cnt  = 2'd0;
        crd_ready = 1'b1;
        tick();
        check_out("bp.b2b", 1, 6, 6, 0);
        tick();
        check_out("bp.done", 0, 0, 0, 1);

        // 4: flush of a partial batch, then flush with nothing held
        free_cnt = 2'd2;
        tick();
        check_out("flush.accum", 0, 0, 2, 0);
        free_cnt = 2'd0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check_out("flush.send", 1, 2, 2, 0);
        tick();
        check_out("flush.done", 0, 0, 0, 1);
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        check_out("flush.empty", 0, 0, 0, 1);

        // 5: free and fire in the same cycle
        crd_ready = 1'b0;
        free_cnt  = 2'd1;
        for (int k = 0; k < 5; k++) tick();
        check_out("same.pre", 1, 4, 5, 0);
        crd_ready = 1'b1;
        free_cnt  = 2'd3;
        tick();
        check_out("same.fire", 1, 4, 4, 0);
        free_cnt = 2'd0;
        tick();
        check_out("same.done", 0, 0, 0, 1);

        // 6: reset while a packet is on the port drops it
        crd_ready = 1'b0;
        free_cnt  = 2'd1;
        for (int k = 0; k < 4; k++) tick();
        check_out("rst.send", 1, 4, 4, 0);
        free_cnt = 2'd0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check_out("rst.after", 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
